// File: rtl/ram_arbiter.sv
`default_nettype none
// ==========================================================================
// ram_arbiter : two-requester round-robin arbiter for a 1W/1R RAM  (rev 1.0)
// ==========================================================================
module ram_arbiter #(
  parameter int AW     = 4,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  output logic [1:0]      req_ready,
  input  logic [1:0]      req_wr,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]      rsp_valid,
  output logic [DW-1:0]   rsp_data,
  output logic            wr_enb,
  output logic [AW-1:0]   wr_addr,
  output logic [DW-1:0]   wr_data,
  output logic            rd_enb,
  output logic [AW-1:0]   rd_addr,
  input  logic [DW-1:0]   rd_data
);

  logic [1:0]    w_wr_req, w_rd_req, w_wr_gnt, w_rd_cand, w_rd_gnt;
  logic [AW-1:0] w_wr_sel_addr, w_rd_sel_addr;
  logic [DW-1:0] w_wr_sel_data;
  logic          w_collide;
  logic          r_wr_pri, r_rd_pri;
  logic [RD_LAT:0] r_pipe_vld, r_pipe_id;

  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic pri);
    if (req == 2'b11) return pri ? 2'b10 : 2'b01;
    return req;
  endfunction

  always_comb begin
    w_wr_req      = rst ? 2'b00 : (req_valid & req_wr);
    w_rd_req      = rst ? 2'b00 : (req_valid & ~req_wr);
    w_wr_gnt      = rr_pick(w_wr_req, r_wr_pri);
    w_rd_cand     = rr_pick(w_rd_req, r_rd_pri);
    w_wr_sel_addr = w_wr_gnt[1]  ? req_addr[2*AW-1:AW]   : req_addr[AW-1:0];
    w_wr_sel_data = w_wr_gnt[1]  ? req_wdata[2*DW-1:DW]  : req_wdata[DW-1:0];
    w_rd_sel_addr = w_rd_cand[1] ? req_addr[2*AW-1:AW]   : req_addr[AW-1:0];
    // A read hitting the address being written this cycle waits, so it sees the new data
    w_collide     = (|w_wr_gnt) && (|w_rd_cand) && (w_wr_sel_addr == w_rd_sel_addr);
    w_rd_gnt      = w_collide ? 2'b00 : w_rd_cand;
    req_ready     = w_wr_gnt | w_rd_gnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_enb     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rd_enb     <= 1'b0;
      rd_addr    <= '0;
      r_wr_pri   <= 1'b0;
      r_rd_pri   <= 1'b0;
      r_pipe_vld <= '0;
      r_pipe_id  <= '0;
      rsp_valid  <= 2'b00;
    end else begin
      wr_enb <= |w_wr_gnt;
      if (|w_wr_gnt) begin
        wr_addr  <= w_wr_sel_addr;
        wr_data  <= w_wr_sel_data;
        r_wr_pri <= ~w_wr_gnt[1];
      end
      rd_enb <= |w_rd_gnt;
      if (|w_rd_gnt) begin
        rd_addr  <= w_rd_sel_addr;
        r_rd_pri <= ~w_rd_gnt[1];
      end
      r_pipe_vld <= {r_pipe_vld[RD_LAT-1:0], |w_rd_gnt};
      r_pipe_id  <= {r_pipe_id[RD_LAT-1:0], w_rd_gnt[1]};
      rsp_valid  <= r_pipe_vld[RD_LAT] ? (r_pipe_id[RD_LAT] ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  assign rsp_data = (|rsp_valid) ? rd_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ==========================================================================
// tb_ram_arbiter : directed self-checking bench for ram_arbiter  (rev 1.0)
// ==========================================================================
module tb_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid, req_ready, req_wr, rsp_valid;
  logic [7:0]    req_addr;
  logic [15:0]   req_wdata;
  logic [7:0]    rsp_data, wr_data, rd_data;
  logic [3:0]    wr_addr, rd_addr;
  logic          wr_enb, rd_enb;

  int n_cmp = 0;
  int n_err = 0;

  ram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // RAM model: rd_data becomes valid RL edges after the edge sampling rd_enb
  logic [7:0] mem [16];
  logic [7:0] rd_pipe [RL+1];
  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    for (int i = 0; i <= RL; i++) rd_pipe[i] = 8'h00;
  end
  always @(posedge clk) begin
    if (wr_enb) mem[wr_addr] <= wr_data;
    rd_pipe[0] <= rd_enb ? mem[rd_addr] : 8'h00;
    for (int k = 1; k <= RL; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign rd_data = rd_pipe[RL];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] wr,
                       input logic [3:0] aa, input logic [3:0] ab,
                       input logic [7:0] da, input logic [7:0] db);
    req_valid = v;
    req_wr    = wr;
    req_addr  = {ab, aa};
    req_wdata = {db, da};
    #1;
  endtask

  task automatic idle();
    req_valid = 2'b00;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [1:0] exp_rdy [4];
  logic [3:0] exp_wa  [4];
  logic [7:0] exp_wd  [4];

  initial begin
    rst = 1'b1;
    req_valid = 2'b00; req_wr = 2'b00; req_addr = '0; req_wdata = '0;
    tick();
    // Commands are refused while reset is asserted
    drive(2'b01, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00);
    check_value("ready_in_rst", req_ready, 2'b00);
    tick();
    check_value("rst_wr_enb", wr_enb, 1'b0);
    check_value("rst_rd_enb", rd_enb, 1'b0);
    check_value("rst_rsp_valid", rsp_valid, 2'b00);
    check_value("rst_rsp_data", rsp_data, 8'h00);
    check_value("rst_wr_addr", wr_addr, 4'd0);
    rst = 1'b0;

    // Single write then read-back
    drive(2'b01, 2'b01, 4'd3, 4'd0, 8'hA5, 8'h00);
    check_value("t1_wr_ready", req_ready, 2'b01);
    tick();
    idle();
    check_value("t1_wr_enb", wr_enb, 1'b1);
    check_value("t1_wr_addr", wr_addr, 4'd3);
    check_value("t1_wr_data", wr_data, 8'hA5);
    drive(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00);
    check_value("t1_rd_ready", req_ready, 2'b01);
    tick();
    idle();
    check_value("t1_rd_enb", rd_enb, 1'b1);
    check_value("t1_rd_addr", rd_addr, 4'd3);
    check_value("t1_wr_enb_idle", wr_enb, 1'b0);
    for (int i = 0; i < RL; i++) tick();
    check_value("t1_rsp_early", rsp_valid, 2'b00);
    tick();
    check_value("t1_rsp_valid", rsp_valid, 2'b01);
    check_value("t1_rsp_data", rsp_data, 8'hA5);
    tick();
    check_value("t1_rsp_done", rsp_valid, 2'b00);

    // Write contention: grants alternate A,B,A,B
    do_reset();
    exp_rdy = '{2'b01, 2'b10, 2'b01, 2'b10};
    exp_wa  = '{4'd1, 4'd2, 4'd1, 4'd2};
    exp_wd  = '{8'h11, 8'h22, 8'h11, 8'h22};
    drive(2'b11, 2'b11, 4'd1, 4'd2, 8'h11, 8'h22);
    for (int i = 0; i < 4; i++) begin
      check_value($sformatf("t2_ready_%0d", i), req_ready, exp_rdy[i]);
      tick();
      check_value($sformatf("t2_wr_addr_%0d", i), wr_addr, exp_wa[i]);
      check_value($sformatf("t2_wr_data_%0d", i), wr_data, exp_wd[i]);
    end
    idle_cycles(2);

    // Concurrent split: A writes while B reads
    drive(2'b11, 2'b01, 4'd5, 4'd6, 8'h55, 8'h00);
    check_value("t3_ready", req_ready, 2'b11);
    tick();
    idle();
    check_value("t3_both_enb", {wr_enb, rd_enb}, 2'b11);
    check_value("t3_wr_addr", wr_addr, 4'd5);
    check_value("t3_rd_addr", rd_addr, 4'd6);
    idle_cycles(6);

    // Collision: B's read of addr 7 waits behind A's write of addr 7
    drive(2'b11, 2'b01, 4'd7, 4'd7, 8'h77, 8'h00);
    check_value("t4_ready_coll", req_ready, 2'b01);
    tick();
    check_value("t4_wr_enb", wr_enb, 1'b1);
    check_value("t4_rd_enb_held", rd_enb, 1'b0);
    drive(2'b10, 2'b00, 4'd0, 4'd7, 8'h00, 8'h00);
    check_value("t4_ready_b", req_ready, 2'b10);
    tick();
    idle();
    check_value("t4_rd_addr", rd_addr, 4'd7);
    for (int i = 0; i < RL; i++) tick();
    check_value("t4_rsp_early", rsp_valid, 2'b00);
    tick();
    check_value("t4_rsp_valid", rsp_valid, 2'b10);
    check_value("t4_rsp_data", rsp_data, 8'h77);
    idle_cycles(4);

    // Pipelined reads: preload addr 0/1, then B reads both back to back
    drive(2'b01, 2'b01, 4'd0, 4'd0, 8'h10, 8'h00);
    tick();
    drive(2'b01, 2'b01, 4'd1, 4'd0, 8'h21, 8'h00);
    tick();
    idle_cycles(2);
    drive(2'b10, 2'b00, 4'd0, 4'd0, 8'h00, 8'h00);
    check_value("t5_ready0", req_ready, 2'b10);
    tick();
    drive(2'b10, 2'b00, 4'd0, 4'd1, 8'h00, 8'h00);
    check_value("t5_ready1", req_ready, 2'b10);
    tick();
    idle();
    tick();
    check_value("t5_rsp_early", rsp_valid, 2'b00);
    tick();
    check_value("t5_rsp0_valid", rsp_valid, 2'b10);
    check_value("t5_rsp0_data", rsp_data, 8'h10);
    tick();
    check_value("t5_rsp1_valid", rsp_valid, 2'b10);
    check_value("t5_rsp1_data", rsp_data, 8'h21);
    tick();
    check_value("t5_rsp_done", rsp_valid, 2'b00);
    idle_cycles(2);

    // Reset one cycle after an accepted read drops its response
    drive(2'b01, 2'b00, 4'd3, 4'd0, 8'h00, 8'h00);
    check_value("t6_ready", req_ready, 2'b01);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_value("t6_outs", {wr_enb, rd_enb, rsp_valid}, 4'b0000);
    check_value("t6_addrs", {wr_addr, rd_addr, wr_data}, 16'h0000);
    for (int i = 0; i < RL + 2; i++) begin
      check_value($sformatf("t6_no_rsp_%0d", i), rsp_valid, 2'b00);
      tick();
    end
    drive(2'b11, 2'b11, 4'd8, 4'd9, 8'h88, 8'h99);
    check_value("t6_wr_pri_reset", req_ready, 2'b01);
    drive(2'b11, 2'b00, 4'd8, 4'd9, 8'h00, 8'h00);
    check_value("t6_rd_pri_reset", req_ready, 2'b01);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
